sysid_access_ctrl: RTL and testbench
====================================

Name: sysid_access_ctrl

Overview:
Sequences and shares the read-only system-ID control slave (1-bit address; word 0 = system ID, word 1 = build timestamp, combinational readdata).
After reset, it performs a boot check: it reads both words, latches the timestamp and flags whether the ID matches.
It then arbitrates two Avalon-MM read masters (CPU data master, JTAG debug master) onto the single slave with round-robin fairness and a fixed 1-cycle read latency.

Parameters:
EXPECTED_ID, 32'd0, system ID value the boot check compares word 0 against.
DATA_W, 32, slave/master data width.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  1  master 0 word address
m0_read  in  1  master 0 read request
m0_waitrequest  out  1  master 0 stall
m0_readdata  out  DATA_W  master 0 read data
m0_readdatavalid  out  1  master 0 data-valid pulse
m1_address, m1_read, m1_waitrequest, m1_readdata, m1_readdatavalid  same as m0, for master 1
s_address  out  1  address to the system-ID slave
s_readdata  in  DATA_W  combinational data from the system-ID slave
boot_done  out  1  boot check complete
id_ok  out  1  latched word 0 == EXPECTED_ID
timestamp  out  DATA_W  latched word 1

Behaviour:
- Reset (async assert, sync release):
  - state = BOOT_ID.
  - m*_waitrequest = 1; m*_readdatavalid = 0; m*_readdata = 0.
  - boot_done = 0; id_ok = 0; timestamp = 0.
  - s_address = 0; last_grant = 1, so m0 wins the first tie.
- FSM states: BOOT_ID -> BOOT_TS -> IDLE. IDLE is terminal until reset.
  - BOOT_ID: s_address = 0. At the clock edge, id_ok <= (s_readdata == EXPECTED_ID).
  - BOOT_TS: s_address = 1. At the clock edge, timestamp <= s_readdata, boot_done <= 1.
  - boot_done rises exactly 2 cycles after reset release. id_ok and timestamp stay stable until the next reset.
- During BOOT_*: both waitrequests are held at 1. Masters must hold read and address per Avalon rules.
- IDLE arbitration:
  - Grant is combinational from m0_read, m1_read and last_grant.
  - Only one requester: that master is granted.
  - Both requesting: the master other than last_grant is granted.
  - Granted master sees waitrequest = 0; the other sees 1. With no requester, both waitrequests = 1.
  - s_address = granted master's address; it stays 0 when idle.
  - A transfer is accepted on any cycle where read && !waitrequest. last_grant is updated at that edge.
- Response path:
  - Accepted read: the granted master's readdata <= s_readdata and readdatavalid <= 1 on the next cycle, as a 1-cycle pulse.
  - The non-granted master's readdata holds its last value, and its readdatavalid = 0.
  - Back-to-back accepts are legal, giving one read per cycle of throughput.
- Fairness under continuous requests from both masters: grants alternate m0, m1, m0, ... Neither master waits more than 1 cycle.
- No write ports. The slave is read-only.
- Reset mid-operation: any pending readdatavalid is dropped immediately. The FSM returns to BOOT_ID and the boot check repeats.

Decomposition:
- Shared package sysid_ctrl_pkg:
  - state enum {BOOT_ID, BOOT_TS, IDLE}.
  - Constants ADDR_ID = 1'b0 and ADDR_TS = 1'b1.
- One sub-module, sysid_rr_arb2:
  - Pure round-robin 2-way arbiter.
  - Inputs: req[1:0], accept, enable. Output: grant[1:0].
  - Holds the last_grant register.
- The top level holds the FSM, the mux and the response registers.

Test Plan:
- Slave model returns ID = 0 and timestamp = 1506519990, EXPECTED_ID = 0. Release reset -> boot_done = 1 at cycle 2, id_ok = 1, timestamp = 1506519990, s_address sequence 0, 1.
- Same slave model, EXPECTED_ID = 32'h1234 -> id_ok = 0 and boot_done = 1. Masters are still serviced normally afterwards.
- m0 reads address 1 in IDLE -> waitrequest = 0 in the same cycle; m0_readdatavalid pulses next cycle with 1506519990; m1 sees no valid.
- m0 and m1 both assert read continuously for 4 cycles -> accepts alternate m0, m1, m0, m1. Each readdatavalid is a 1-cycle pulse on the correct master with data matching its address.
- m1 asserts read during boot -> m1_waitrequest = 1 until IDLE; accepted in the first IDLE cycle; data valid one cycle later.
- Assert reset_n low on the cycle after an accept -> readdatavalid = 0 immediately, boot_done = 0. After release, the boot sequence repeats and m0 wins the first tie.

Source files
------------

// File: rtl/sysid_ctrl_pkg.sv
// rtl/sysid_ctrl_pkg.sv - shared types and constants for the system-ID access controller
package sysid_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT_ID = 2'd0,
    BOOT_TS = 2'd1,
    IDLE    = 2'd2
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_rr_arb2.sv
// rtl/sysid_rr_arb2.sv - two-way round-robin arbiter with registered last-grant
module sysid_rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       accept,
  input  logic       enable,
  output logic [1:0] grant
);

  // last_grant is the index of the master served most recently; starts at 1 so m0 wins the first tie
  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (accept && enable) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/sysid_access_ctrl.sv
// rtl/sysid_access_ctrl.sv - boot check and two-master read sharing of the system-ID slave
module sysid_access_ctrl
  import sysid_ctrl_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] EXPECTED_ID = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              m0_address,
  input  logic              m0_read,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic              m1_address,
  input  logic              m1_read,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              s_address,
  input  logic [DATA_W-1:0] s_readdata,
  output logic              boot_done,
  output logic              id_ok,
  output logic [DATA_W-1:0] timestamp
);

  state_t     state;
  logic [1:0] grant;
  logic       arb_enable;
  logic       accept0;
  logic       accept1;

  assign arb_enable = (state == IDLE);

  sysid_rr_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     ({m1_read, m0_read}),
    .accept  (accept0 | accept1),
    .enable  (arb_enable),
    .grant   (grant)
  );

  // Slave readdata is combinational, so acceptance and sampling happen on the same edge
  assign accept0 = m0_read && grant[0];
  assign accept1 = m1_read && grant[1];

  assign m0_waitrequest = !grant[0];
  assign m1_waitrequest = !grant[1];

  always_comb begin
    s_address = ADDR_ID;
    case (state)
      BOOT_ID: s_address = ADDR_ID;
      BOOT_TS: s_address = ADDR_TS;
      IDLE: begin
        if (grant[0]) begin
          s_address = m0_address;
        end else if (grant[1]) begin
          s_address = m1_address;
        end
      end
      default: s_address = ADDR_ID;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= BOOT_ID;
      id_ok     <= 1'b0;
      timestamp <= '0;
      boot_done <= 1'b0;
    end else begin
      case (state)
        BOOT_ID: begin
          id_ok <= (s_readdata == EXPECTED_ID);
          state <= BOOT_TS;
        end
        BOOT_TS: begin
          timestamp <= s_readdata;
          boot_done <= 1'b1;
          state     <= IDLE;
        end
        IDLE:    state <= IDLE;
        default: state <= BOOT_ID;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m0_readdata      <= '0;
      m0_readdatavalid <= 1'b0;
      m1_readdata      <= '0;
      m1_readdatavalid <= 1'b0;
    end else begin
      m0_readdatavalid <= accept0;
      m1_readdatavalid <= accept1;
      if (accept0) begin
        m0_readdata <= s_readdata;
      end
      if (accept1) begin
        m1_readdata <= s_readdata;
      end
    end
  end

endmodule

// File: tb/tb_sysid_access_ctrl.sv
// tb/tb_sysid_access_ctrl.sv - scoreboard bench for sysid_access_ctrl
module tb_sysid_access_ctrl;

  localparam int          DATA_W = 32;
  localparam logic [31:0] ID_VAL = 32'd0;
  localparam logic [31:0] TS_VAL = 32'd1506519990;

  logic        clock;
  logic        reset_n;
  logic        m0_address, m0_read, m1_address, m1_read;

  logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata, s_readdata, timestamp;
  logic        s_address, boot_done, id_ok;

  logic        b_m0_waitrequest, b_m0_readdatavalid, b_m1_waitrequest, b_m1_readdatavalid;
  logic [31:0] b_m0_readdata, b_m1_readdata, b_s_readdata, b_timestamp;
  logic        b_s_address, b_boot_done, b_id_ok;

  assign s_readdata   = s_address   ? TS_VAL : ID_VAL;
  assign b_s_readdata = b_s_address ? TS_VAL : ID_VAL;

  sysid_access_ctrl #(.DATA_W(DATA_W), .EXPECTED_ID(32'd0)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_readdata(s_readdata),
    .boot_done(boot_done), .id_ok(id_ok), .timestamp(timestamp)
  );

  sysid_access_ctrl #(.DATA_W(DATA_W), .EXPECTED_ID(32'h1234)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(b_m0_waitrequest),
    .m0_readdata(b_m0_readdata), .m0_readdatavalid(b_m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_waitrequest(b_m1_waitrequest),
    .m1_readdata(b_m1_readdata), .m1_readdatavalid(b_m1_readdatavalid),
    .s_address(b_s_address), .s_readdata(b_s_readdata),
    .boot_done(b_boot_done), .id_ok(b_id_ok), .timestamp(b_timestamp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        mst;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          phase;
  logic        model_last;
  logic [31:0] last0, last1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    phase      = 0;
    model_last = 1'b1;
    last0      = '0;
    last1      = '0;
    sb.delete();
  endtask

  task automatic step(input logic r0, input logic a0, input logic r1, input logic a1);
    logic [1:0] g;
    logic       exp_sa;
    logic       v0, v1;
    exp_t       e;
    m0_read = r0; m0_address = a0; m1_read = r1; m1_address = a1;
    #1;
    g = 2'b00;
    if (phase == 2) begin
      if (r0 && r1) g = model_last ? 2'b01 : 2'b10;
      else          g = {r1, r0};
    end
    if (phase == 0)      exp_sa = 1'b0;
    else if (phase == 1) exp_sa = 1'b1;
    else                 exp_sa = g[0] ? a0 : (g[1] ? a1 : 1'b0);
    chk("m0_waitrequest", 32'(m0_waitrequest), 32'(!g[0]));
    chk("m1_waitrequest", 32'(m1_waitrequest), 32'(!g[1]));
    chk("b_m1_waitrequest", 32'(b_m1_waitrequest), 32'(!g[1]));
    chk("s_address", 32'(s_address), 32'(exp_sa));
    if (g[0]) sb.push_back('{mst: 1'b0, data: (a0 ? TS_VAL : ID_VAL)});
    if (g[1]) sb.push_back('{mst: 1'b1, data: (a1 ? TS_VAL : ID_VAL)});
    @(posedge clock);
    #1;
    if (g != 2'b00) model_last = g[1];
    if (phase < 2) phase++;
    v0 = 1'b0; v1 = 1'b0;
    if (g != 2'b00 && sb.size() > 0) begin
      e = sb.pop_front();
      if (e.mst) begin v1 = 1'b1; last1 = e.data; end
      else       begin v0 = 1'b1; last0 = e.data; end
    end
    chk("m0_readdatavalid", 32'(m0_readdatavalid), 32'(v0));
    chk("m1_readdatavalid", 32'(m1_readdatavalid), 32'(v1));
    chk("m0_readdata", m0_readdata, last0);
    chk("m1_readdata", m1_readdata, last1);
    chk("b_m0_readdatavalid", 32'(b_m0_readdatavalid), 32'(v0));
    chk("b_m1_readdata", b_m1_readdata, last1);
    chk("boot_done", 32'(boot_done), 32'(phase == 2));
    chk("id_ok", 32'(id_ok), 32'(phase >= 1));
    chk("timestamp", timestamp, (phase == 2) ? TS_VAL : 32'd0);
    chk("b_boot_done", 32'(b_boot_done), 32'(phase == 2));
    chk("b_id_ok", 32'(b_id_ok), 32'd0);
  endtask

  task automatic reset_checks();
    chk("rst_m0_waitrequest", 32'(m0_waitrequest), 32'd1);
    chk("rst_m1_waitrequest", 32'(m1_waitrequest), 32'd1);
    chk("rst_m0_readdatavalid", 32'(m0_readdatavalid), 32'd0);
    chk("rst_m1_readdatavalid", 32'(m1_readdatavalid), 32'd0);
    chk("rst_m0_readdata", m0_readdata, 32'd0);
    chk("rst_m1_readdata", m1_readdata, 32'd0);
    chk("rst_boot_done", 32'(boot_done), 32'd0);
    chk("rst_id_ok", 32'(id_ok), 32'd0);
    chk("rst_timestamp", timestamp, 32'd0);
    chk("rst_s_address", 32'(s_address), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    m0_read = 1'b0; m0_address = 1'b0; m1_read = 1'b0; m1_address = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset_checks();
    reset_n = 1'b1;

    // m1 requests through boot; served in the first IDLE cycle
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);

    // valid pulse from the last accept is high now; reset must drop it at once
    chk("pre_rst_m0_readdatavalid", 32'(m0_readdatavalid), 32'd1);
    reset_n = 1'b0;
    m0_read = 1'b0; m1_read = 1'b0;
    #1;
    reset_checks();
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
